quad_encoder_tx: RTL and testbench

//  Quadrature encoder emitter: the transmit end of the rotary-encoder A/B interface that the mixer decodes.

---
 rtl/quad_pkg.sv | 20 ++
 rtl/quad_phase_timer.sv | 28 ++
 rtl/quad_encoder_tx.sv | 142 ++++++++++++++
 tb/tb_quad_encoder_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and Gray tables for the quadrature encoder emitter.
// No logic; constant lookups only.
package quad_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b1;

  // {A,B} after phase index 0..3 within a step; index 0 is the 00 rest state
  localparam logic [1:0] FWD_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  localparam logic [1:0] REV_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic [1:0] seq_ab(input logic dir, input logic [1:0] ph);
    return (dir == DIR_FWD) ? FWD_SEQ[ph] : REV_SEQ[ph];
  endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Edge-spacing down-counter: tick pulses one cycle, div cycles after each load.
// Latency: first tick div cycles after load. No backpressure; en gates the tick.
module quad_phase_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = en && (cnt == DIV_W'(1));

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature A/B emitter with signed position; optional index pulse under QUAD_INDEX_EN.
// Latency: edge k at accept + k*div cycles. Backpressure: cmd_ready low for the whole run, no queueing.
module quad_encoder_tx
  import quad_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16,
  parameter int POS_W = 16,
  parameter int PPR   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic [DIV_W-1:0]        phase_div,
  input  logic                    cmd_stop,
  output logic                    busy,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_z,
  output logic signed [POS_W-1:0] position
);

  state_t                  state, state_nxt;
  logic                    dir_q;
  logic [CNT_W-1:0]        rem_q;
  logic [DIV_W-1:0]        div_q;
  logic [1:0]              ph_q;
  logic                    stop_q;
  logic [1:0]              ab_q;
  logic signed [POS_W-1:0] pos_q;

  logic             accept, tick, edge_en, step_done, stop_now;
  logic [DIV_W-1:0] eff_div, tmr_div;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign eff_div   = (phase_div == '0) ? DIV_W'(1) : phase_div;
  assign tmr_div   = accept ? eff_div : div_q;
  // A zero-step command still runs the timer; its tick must not emit an edge
  assign edge_en   = tick && (rem_q != '0);
  assign step_done = edge_en && (ph_q == 2'd3);
  assign stop_now  = stop_q || cmd_stop;

  quad_phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == ST_RUN),
    .load    (accept || edge_en),
    .div     (tmr_div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        if (rem_q == '0)
          state_nxt = ST_IDLE;
        else if (step_done && ((rem_q == CNT_W'(1)) || stop_now))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q  <= DIR_FWD;
      rem_q  <= '0;
      div_q  <= '0;
      ph_q   <= '0;
      stop_q <= 1'b0;
      ab_q   <= 2'b00;
      pos_q  <= '0;
    end else if (accept) begin
      dir_q  <= cmd_dir;
      rem_q  <= cmd_steps;
      div_q  <= eff_div;
      ph_q   <= '0;
      stop_q <= 1'b0;
    end else if (state == ST_RUN) begin
      if (cmd_stop) stop_q <= 1'b1;
      if (edge_en) begin
        ph_q <= ph_q + 2'd1;
        ab_q <= seq_ab(dir_q, ph_q + 2'd1);
        if (ph_q == 2'd3) begin
          rem_q <= rem_q - CNT_W'(1);
          pos_q <= (dir_q == DIR_FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
      end
    end
  end

  assign enc_a    = ab_q[1];
  assign enc_b    = ab_q[0];
  assign position = pos_q;

`ifdef QUAD_INDEX_EN
  localparam int IDX_W = (PPR > 1) ? $clog2(PPR) : 1;

  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [DIV_W-1:0] z_cnt;

  // idx_q tracks position mod PPR without a divider
  always_comb begin
    idx_nxt = idx_q;
    if (dir_q == DIR_FWD)
      idx_nxt = (idx_q == IDX_W'(PPR - 1)) ? '0 : idx_q + IDX_W'(1);
    else
      idx_nxt = (idx_q == '0) ? IDX_W'(PPR - 1) : idx_q - IDX_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      z_cnt <= '0;
    end else if (step_done) begin
      idx_q <= idx_nxt;
      z_cnt <= (idx_nxt == '0) ? div_q : '0;
    end else if (edge_en) begin
      z_cnt <= '0;
    end else if (z_cnt != '0) begin
      z_cnt <= z_cnt - DIV_W'(1);
    end
  end

  assign enc_z = (z_cnt != '0);
`else
  assign enc_z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Directed bench for quad_encoder_tx; a second instance with POS_W=8 exercises position wrap cheaply.
`timescale 1ns/1ps
module tb_quad_encoder_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_dir, cmd_stop;
  logic [7:0]  cmd_steps;
  logic [15:0] phase_div;

  logic        cmd_ready, busy, enc_a, enc_b, enc_z;
  logic [15:0] position;
  logic        cmd_ready_w, busy_w, enc_a_w, enc_b_w, enc_z_w;
  logic [7:0]  position_w;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] fwd_tbl [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_tbl [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  always #5 clk = ~clk;

  quad_encoder_tx dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .phase_div(phase_div), .cmd_stop(cmd_stop),
    .busy(busy), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .position(position)
  );

  quad_encoder_tx #(.POS_W(8)) dut_w (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .phase_div(phase_div), .cmd_stop(cmd_stop),
    .busy(busy_w), .enc_a(enc_a_w), .enc_b(enc_b_w), .enc_z(enc_z_w), .position(position_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks, leaving the bench at the negedge after the last posedge
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Returns at the negedge following the accept edge (t=0 of the command)
  task automatic send(input logic dir, input logic [7:0] steps, input logic [15:0] div);
    @(negedge clk);
    check("send_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    phase_div = div;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      tick_n(1);
      n++;
    end
    check(tag, cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_stop  = 1'b0;
    cmd_steps = '0;
    phase_div = '0;
    #1;
    check("rst_ab",    {enc_a, enc_b}, 2'b00);
    check("rst_z",     enc_z, 0);
    check("rst_pos",   position, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy",  busy, 0);
    tick_n(2);
    reset_n = 1'b1;

    // Forward, 2 steps, div 3
    send(1'b1, 8'd2, 16'd3);
    check("fwd_busy0", busy, 1);
    for (int t = 1; t <= 25; t++) begin
      tick_n(1);
      if (t == 2)      check("fwd_ab_pre", {enc_a, enc_b}, 2'b00);
      if (t % 3 == 0)  check($sformatf("fwd_ab_t%0d", t), {enc_a, enc_b}, fwd_tbl[(t/3 - 1) % 4]);
      if (t == 11)     check("fwd_pos_t11", position, 0);
      if (t == 12)     check("fwd_pos_t12", position, 1);
      if (t == 23)     check("fwd_busy_t23", busy, 1);
      if (t == 24)     check("fwd_pos_t24", position, 2);
      if (t == 25)     check("fwd_ready_t25", cmd_ready, 1);
    end

    // Reverse, 1 step, div 0 (as 1); a different command is held valid during the run
    send(1'b0, 8'd1, 16'd0);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd9;
    phase_div = 16'd7;
    for (int t = 1; t <= 4; t++) begin
      tick_n(1);
      check($sformatf("rev_ab_t%0d", t), {enc_a, enc_b}, rev_tbl[t-1]);
    end
    cmd_valid = 1'b0;
    check("rev_pos",   position, 1);
    check("rev_ready", cmd_ready, 1);
    tick_n(3);
    check("rev_noacc_ready", cmd_ready, 1);
    check("rev_rest_ab",     {enc_a, enc_b}, 2'b00);
    check("rev_rest_pos",    position, 1);

    // Zero steps: one RUN cycle, no edges even with div 1
    send(1'b1, 8'd0, 16'd1);
    check("zero_busy0", busy, 1);
    tick_n(1);
    check("zero_busy1", busy, 0);
    check("zero_ab",    {enc_a, enc_b}, 2'b00);
    check("zero_pos",   position, 1);

    // Stop after edge 5 of a 3-step command pads to edge 8
    send(1'b1, 8'd3, 16'd2);
    for (int t = 1; t <= 18; t++) begin
      tick_n(1);
      if (t == 10) begin
        check("stop_ab_e5", {enc_a, enc_b}, 2'b10);
        cmd_stop = 1'b1;
      end
      if (t == 11) cmd_stop = 1'b0;
      if (t == 14) check("stop_busy_t14", busy, 1);
      if (t == 16) begin
        check("stop_ab_e8",  {enc_a, enc_b}, 2'b00);
        check("stop_pos",    position, 3);
        check("stop_ready",  cmd_ready, 1);
      end
      if (t == 18) begin
        check("stop_ab_after",  {enc_a, enc_b}, 2'b00);
        check("stop_pos_after", position, 3);
      end
    end

    // Asynchronous reset after 3 edges of a step
    send(1'b1, 8'd1, 16'd2);
    tick_n(6);
    check("mrst_ab_pre",  {enc_a, enc_b}, 2'b01);
    check("mrst_pos_pre", position, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_ab",    {enc_a, enc_b}, 2'b00);
    check("mrst_pos",   position, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_busy",  busy, 0);
    tick_n(2);
    reset_n = 1'b1;

    // Wrap: 8-bit instance goes 0x7F -> 0x80 -> 0x7F
    send(1'b1, 8'd127, 16'd1);
    wait_idle("wrap_run127_done", 600);
    check("wrap_pos_w_7f", position_w, 8'h7F);
    check("wrap_pos_7f",   position, 16'h007F);
    send(1'b1, 8'd1, 16'd1);
    wait_idle("wrap_fwd_done", 20);
    check("wrap_pos_w_80", position_w, 8'h80);
    check("wrap_pos_80",   position, 16'h0080);
    send(1'b0, 8'd1, 16'd1);
    wait_idle("wrap_rev_done", 20);
    check("wrap_pos_w_back", position_w, 8'h7F);
    check("wrap_pos_back",   position, 16'h007F);

    // Index: 4 forward steps at div 5, position mod 4 hits 0 only at edge 16
    @(negedge clk);
    reset_n = 1'b0;
    tick_n(2);
    reset_n = 1'b1;
    send(1'b1, 8'd4, 16'd5);
    for (int t = 1; t <= 90; t++) begin
      logic exp_z;
      tick_n(1);
`ifdef QUAD_INDEX_EN
      exp_z = (t >= 80 && t < 85);
`else
      exp_z = 1'b0;
`endif
      check($sformatf("idx_z_t%0d", t), enc_z, exp_z);
    end
    check("idx_pos", position, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
